polar_encoder: RTL and testbench
================================

POLAR_ENCODER -- requirements
Module: polar_encoder

Interface
REQ-001 SHALL have parameter N, default 8; code length, power of two, 4..1024.
REQ-002 SHALL have parameter K, default 4; information bits per codeword, 1..N.
REQ-003 SHALL have parameter FROZEN_MASK[N-1:0], default 8'b0001_0111; bit i=1 marks u_i frozen (forced 0); popcount of zeros SHALL equal K.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  in_info holds a frame.
REQ-007 SHALL have port in_ready  output  1  encoder accepts a frame this cycle.
REQ-008 SHALL have port in_info  input  K  info bits; in_info[m] maps to the m-th unfrozen index, ascending.
REQ-009 SHALL have port out_valid  output  1  out_code holds a codeword.
REQ-010 SHALL have port out_ready  input  1  sink accepts the codeword.
REQ-011 SHALL have port out_code  output  N  codeword; bit j = x_j.
REQ-012 SHALL have port frame_cnt  output  16  codewords delivered since reset.

Function
REQ-013 SHALL compute x = u * F^(xor-kron log2N), F=[[1,0],[1,1]], i.e. x_j = XOR of u_i over all i where (j & ~i)==0.
REQ-014 SHALL realise the transform as LOG2N butterfly stages, each followed by a register with its own valid bit.
REQ-015 SHALL accept a frame when in_valid && in_ready; latency acceptance-to-out_valid SHALL be exactly LOG2N cycles with no stall.
REQ-016 SHALL drive in_ready = !out_valid || out_ready (global pipeline advance); all stages advance together.
REQ-017 SHALL sustain one frame per cycle when out_ready is held high.
REQ-018 SHALL hold out_code and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL insert bubbles (valid=0) when advancing without an accepted input; bubbles never assert out_valid.
REQ-020 SHALL increment frame_cnt by 1 on each out_valid && out_ready; wraps 16'hFFFF -> 0.
REQ-021 SHALL ignore in_info when in_valid=0; the value of frozen positions is never taken from in_info.
REQ-022 SHALL, with in and out handshakes in the same cycle and a full pipeline, both deliver and accept without loss.

Reset
REQ-023 SHALL, on rst_n low, clear all stage valid bits, stage data, out_valid, frame_cnt to 0 immediately.
REQ-024 SHALL drive in_ready=1 while in reset and the first cycle after release.
REQ-025 SHALL discard in-flight frames on reset mid-operation; none emerge after release.

Configuration
REQ-026 SHALL, with POLAR_ENC_BITREV_EN defined, present out_code[j] = x[bitrev_LOG2N(j)] (bit-reversed order).
REQ-027 SHALL, without POLAR_ENC_BITREV_EN, present natural order; latency and handshake identical in both builds.

Structure
REQ-028 SHALL place N default, LOG2N, default FROZEN_MASK, and bitrev function in shared package polar_pkg, reused by the decoder.
REQ-029 SHALL implement one stage as sub-module polar_butterfly_stage (parameters N, STAGE; combinational XOR plus valid/data register with enable).
REQ-030 SHALL build the info-to-u mapping at elaboration from FROZEN_MASK; no runtime mask.

Verification (N=8, K=4, default mask, info at u3,u5,u6,u7)
REQ-031 SHALL check in_info=4'b0001, out_ready=1 -> out_code=8'h0F exactly 3 cycles after acceptance; with POLAR_ENC_BITREV_EN -> 8'h55.
REQ-032 SHALL check in_info=4'b1000 -> 8'hFF; 4'b1111 -> 8'h96; 4'b0000 -> 8'h00.
REQ-033 SHALL check back-to-back 16 frames, out_ready=1 -> 16 codewords on consecutive cycles, in order, frame_cnt=16.
REQ-034 SHALL check out_ready=0 for 5 cycles with pipeline full -> out_code stable, in_ready=0, no frame lost or duplicated after release.
REQ-035 SHALL check rst_n pulsed low with 2 frames in flight -> out_valid=0, frame_cnt=0 immediately; no stale codeword after release.
REQ-036 SHALL check 65537 delivered frames -> frame_cnt=1 (wrap).

Source files
------------

// File: rtl/polar_pkg.sv
// Shared polar-code definitions used by the encoder and the decoder:
// default code size, default frozen-bit mask and the bit-reversal helper.
package polar_pkg;

  localparam int POLAR_N_DEFAULT = 8;
  localparam int POLAR_LOG2N     = $clog2(POLAR_N_DEFAULT);

  // Bit i set means u_i is frozen to zero; the clear bits (u3, u5, u6, u7) carry information.
  localparam logic [POLAR_N_DEFAULT-1:0] POLAR_FROZEN_MASK_DEFAULT = 8'b0001_0111;

  // Reverse the low nbits of idx.
  function automatic int polar_bitrev(input int idx, input int nbits);
    int r;
    r = 0;
    for (int b = 0; b < nbits; b++) begin
      if (((idx >> b) & 1) == 1) r = r | (1 << (nbits - 1 - b));
    end
    return r;
  endfunction

endpackage

// File: rtl/polar_butterfly_stage.sv
// One polar transform stage: an XOR butterfly across index distance
// 2**STAGE, followed by a data/valid register that loads only when enabled.
module polar_butterfly_stage
  import polar_pkg::*;
#(
  parameter int N     = POLAR_N_DEFAULT,
  parameter int STAGE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_valid,
  input  logic [N-1:0] i_data,
  output logic         o_valid,
  output logic [N-1:0] o_data
);

  localparam int SPAN = 2 ** STAGE;

  logic [N-1:0] w_x;
  logic         r_valid;
  logic [N-1:0] r_data;

  // The lower index of each pair absorbs its partner; the upper index passes through.
  for (genvar j = 0; j < N; j++) begin : g_bfly
    if ((j / SPAN) % 2 == 0) begin : g_low
      assign w_x[j] = i_data[j] ^ i_data[j+SPAN];
    end else begin : g_high
      assign w_x[j] = i_data[j];
    end
  end

  // Stage register; holds its contents whenever the pipeline is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= w_x;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/polar_encoder.sv
// Pipelined polar encoder: x = u * F^(kron log2N), one butterfly stage per
// clock, LOG2N cycles from acceptance to out_valid, all stages advancing
// together under a single ready/valid backpressure signal.
// Build option: POLAR_ENC_BITREV_EN presents the codeword in bit-reversed order.
module polar_encoder
  import polar_pkg::*;
#(
  parameter int           N           = POLAR_N_DEFAULT,
  parameter int           K           = 4,
  parameter logic [N-1:0] FROZEN_MASK = POLAR_FROZEN_MASK_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_info,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_code,
  output logic [15:0]  frame_cnt
);

  localparam int LOG2N = $clog2(N);

  // Position of unfrozen index idx among the unfrozen indices, counted from zero.
  function automatic int unfrozen_rank(input int idx);
    int r;
    r = 0;
    for (int b = 0; b < idx; b++) begin
      if (!FROZEN_MASK[b]) r++;
    end
    return r;
  endfunction

  logic                     w_advance;
  logic [N-1:0]             w_u;
  logic [LOG2N:0]           w_valid;
  logic [LOG2N:0][N-1:0]    w_data;
  logic [15:0]              r_frame_cnt;

  // Frozen positions are tied to zero; info bits are gated so an idle input never reaches the stages.
  for (genvar i = 0; i < N; i++) begin : g_map
    if (FROZEN_MASK[i] || unfrozen_rank(i) >= K) begin : g_frozen
      assign w_u[i] = 1'b0;
    end else begin : g_info
      assign w_u[i] = in_valid & in_info[unfrozen_rank(i)];
    end
  end

  assign w_advance  = !w_valid[LOG2N] || out_ready;
  assign w_valid[0] = in_valid;
  assign w_data[0]  = w_u;

  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    polar_butterfly_stage #(
      .N     (N),
      .STAGE (s)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_advance),
      .i_valid (w_valid[s]),
      .i_data  (w_data[s]),
      .o_valid (w_valid[s+1]),
      .o_data  (w_data[s+1])
    );
  end

`ifdef POLAR_ENC_BITREV_EN
  for (genvar j = 0; j < N; j++) begin : g_bitrev
    assign out_code[j] = w_data[LOG2N][polar_bitrev(j, LOG2N)];
  end
`else
  assign out_code = w_data[LOG2N];
`endif

  // Count delivered codewords; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_valid[LOG2N] && out_ready) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign in_ready  = w_advance;
  assign out_valid = w_valid[LOG2N];
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_polar_encoder.sv
// Directed bench for polar_encoder at N=8, K=4 with the default frozen mask.
module tb_polar_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [3:0]  in_info;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_code;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  // Codewords of the four single-bit info words, worked out by hand from
  // x_j = XOR of u_i over supersets i of j (info bits sit at u3, u5, u6, u7).
`ifdef POLAR_ENC_BITREV_EN
  localparam logic [7:0] B0 = 8'h55, B1 = 8'h33, B2 = 8'h0F, B3 = 8'hFF;
`else
  localparam logic [7:0] B0 = 8'h0F, B1 = 8'h33, B2 = 8'h55, B3 = 8'hFF;
`endif

  always #5 clk = ~clk;

  polar_encoder #(
    .N           (8),
    .K           (4),
    .FROZEN_MASK (8'b0001_0111)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_info   (in_info),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .frame_cnt (frame_cnt)
  );

  function automatic logic [7:0] exp_code(input logic [3:0] info);
    logic [7:0] c;
    c = 8'h00;
    if (info[0]) c = c ^ B0;
    if (info[1]) c = c ^ B1;
    if (info[2]) c = c ^ B2;
    if (info[3]) c = c ^ B3;
    return c;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // One isolated frame: out_valid must rise exactly three cycles after acceptance.
  task automatic send_single(input logic [3:0] info, input logic [7:0] exp, input string tag);
    check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_info  = info;
    step();
    in_valid = 1'b0;
    in_info  = ~info;
    check_eq({tag, "_vld1"}, 32'(out_valid), 32'd0);
    step();
    check_eq({tag, "_vld2"}, 32'(out_valid), 32'd0);
    step();
    check_eq({tag, "_vld3"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_code"}, 32'(out_code), 32'(exp));
    step();
    check_eq({tag, "_bubble"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_info   = 4'h0;
    out_ready = 1'b1;

    step();
    step();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_eq("rst_out_code",  32'(out_code),  32'd0);
    rst_n = 1'b1;
    check_eq("post_rst_ready", 32'(in_ready), 32'd1);

`ifdef POLAR_ENC_BITREV_EN
    send_single(4'b0001, 8'h55, "v0001");
`else
    send_single(4'b0001, 8'h0F, "v0001");
`endif
    send_single(4'b1000, 8'hFF, "v1000");
    send_single(4'b1111, 8'h96, "v1111");
    send_single(4'b0000, 8'h00, "v0000");
    check_eq("single_cnt", 32'(frame_cnt), 32'd4);

    // Sixteen back-to-back frames with the sink always ready.
    apply_reset();
    for (int c = 0; c < 21; c++) begin
      in_valid = (c < 16);
      in_info  = 4'(c);
      step();
      check_eq("b2b_vld", 32'(out_valid), 32'((c >= 2) && (c <= 17)));
      if ((c >= 2) && (c <= 17)) check_eq("b2b_code", 32'(out_code), 32'(exp_code(4'(c - 2))));
    end
    check_eq("b2b_cnt", 32'(frame_cnt), 32'd16);

    // Fill the pipeline against a stalled sink, hold for five cycles, then release.
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_info   = 4'd1;
    step();
    in_info = 4'd2;
    step();
    in_info = 4'd3;
    step();
    in_info = 4'd4;
    for (int c = 0; c < 5; c++) begin
      check_eq("stall_vld",  32'(out_valid), 32'd1);
      check_eq("stall_code", 32'(out_code),  32'(exp_code(4'd1)));
      check_eq("stall_rdy",  32'(in_ready),  32'd0);
      step();
    end
    check_eq("stall_cnt", 32'(frame_cnt), 32'd0);
    out_ready = 1'b1;
    #1;
    check_eq("release_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    for (int f = 2; f <= 4; f++) begin
      check_eq("drain_vld",  32'(out_valid), 32'd1);
      check_eq("drain_code", 32'(out_code),  32'(exp_code(4'(f))));
      step();
    end
    check_eq("drain_end_vld", 32'(out_valid), 32'd0);
    check_eq("drain_cnt",     32'(frame_cnt), 32'd4);

    // Reset with one frame at the output and two more in flight.
    in_valid = 1'b1;
    for (int c = 5; c <= 7; c++) begin
      in_info = 4'(c);
      step();
    end
    in_valid = 1'b0;
    check_eq("pre_rst_vld",  32'(out_valid), 32'd1);
    check_eq("pre_rst_code", 32'(out_code),  32'(exp_code(4'd5)));
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vld", 32'(out_valid), 32'd0);
    check_eq("mid_rst_cnt", 32'(frame_cnt), 32'd0);
    check_eq("mid_rst_rdy", 32'(in_ready),  32'd1);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check_eq("no_stale_vld", 32'(out_valid), 32'd0);
    end
    check_eq("no_stale_cnt", 32'(frame_cnt), 32'd0);

    // 65537 deliveries wrap the counter to one.
    apply_reset();
    for (int e = 1; e <= 65540; e++) begin
      in_valid = (e <= 65537);
      in_info  = 4'(e);
      step();
      if (e == 65538) check_eq("wrap_ffff", 32'(frame_cnt), 32'h0000FFFF);
    end
    check_eq("wrap_cnt", 32'(frame_cnt), 32'd1);
    check_eq("wrap_idle", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
